// File: rtl/simd_vector_feeder_if.sv
// Bundle of the simd_vector_feeder buffer-write, command, MAC stream, MAC result and
// result-handshake signals.
//   master : the environment side (drives writes, commands, MAC results, res_ready_i)
//   slave  : the feeder side (drives cmd_ready_o, the beat stream and the result)
// A_o/B_o are lane-packed: lane i occupies [i].
interface simd_vector_feeder_if #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned ELEM_W         = 16,
  parameter int unsigned MAX_NUM_ELEM   = 64,
  parameter int unsigned VEC_MAC_DATA_W = 2 * ELEM_W + $clog2(MAX_NUM_ELEM)
);
  localparam int unsigned AW = $clog2(MAX_NUM_ELEM);

  // Buffer writes
  logic                                wr_en_i;
  logic                                wr_sel_i;
  logic [AW-1:0]                       wr_addr_i;
  logic signed [ELEM_W-1:0]            wr_data_i;
  // Command
  logic                                cmd_valid_i;
  logic                                cmd_ready_o;
  logic [AW:0]                         cmd_len_i;
  // MAC-side stream
  logic                                valid_o;
  logic                                start_o;
  logic                                last_o;
  logic [NUM_LANES-1:0][ELEM_W-1:0]    A_o;
  logic [NUM_LANES-1:0][ELEM_W-1:0]    B_o;
  // MAC result
  logic                                mac_valid_i;
  logic signed [VEC_MAC_DATA_W-1:0]    mac_data_i;
  // Result handshake
  logic                                res_valid_o;
  logic                                res_ready_i;
  logic signed [VEC_MAC_DATA_W-1:0]    res_data_o;
  logic                                busy_o;

  modport master (
    output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i,
    output cmd_valid_i, cmd_len_i,
    input  cmd_ready_o,
    input  valid_o, start_o, last_o, A_o, B_o,
    output mac_valid_i, mac_data_i,
    input  res_valid_o, res_data_o, busy_o,
    output res_ready_i
  );

  modport slave (
    input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i,
    input  cmd_valid_i, cmd_len_i,
    output cmd_ready_o,
    output valid_o, start_o, last_o, A_o, B_o,
    input  mac_valid_i, mac_data_i,
    output res_valid_o, res_data_o, busy_o,
    input  res_ready_i
  );
endinterface

// File: rtl/simd_vector_feeder.sv
// simd_vector_feeder: holds two element buffers (A and B), and on a command streams
// ceil(len/NUM_LANES) lane-packed beats of both operands to a MAC, then captures the MAC
// result and holds it until the consumer accepts it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : simd_vector_feeder_if.slave (writes, command, beat stream, MAC result,
//                result handshake, busy)
module simd_vector_feeder #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned ELEM_W         = 16,
  parameter int unsigned MAX_NUM_ELEM   = 64,
  parameter int unsigned VEC_MAC_DATA_W = 2 * ELEM_W + $clog2(MAX_NUM_ELEM)
) (
  input logic                  clk,
  input logic                  rst_n,
  simd_vector_feeder_if.slave  bus
);
  localparam int unsigned AW = $clog2(MAX_NUM_ELEM);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_NUM_ELEM / NUM_LANES) + 1;

  typedef enum logic [1:0] {StIdle, StStream, StWaitRes, StHoldRes} state_e;

  state_e                            state_q;
  logic [ELEM_W-1:0]                 buf_a [MAX_NUM_ELEM];
  logic [ELEM_W-1:0]                 buf_b [MAX_NUM_ELEM];
  logic [LW-1:0]                     len_q;
  logic [BW-1:0]                     beat_q;
  logic                              valid_q, start_q, last_q, res_valid_q;
  logic [NUM_LANES-1:0][ELEM_W-1:0]  a_q, b_q;
  logic signed [VEC_MAC_DATA_W-1:0]  res_data_q;

  logic                              wr_ok, accept, is_last;
  logic [LW-1:0]                     cmd_len_clamp, sel_len;
  logic [BW-1:0]                     sel_beat, num_beats;
  logic [LW:0]                       len_round;
  logic [NUM_LANES-1:0][LW-1:0]      lane_idx;
  logic [NUM_LANES-1:0][ELEM_W-1:0]  lane_a, lane_b;

  assign wr_ok         = bus.wr_en_i && (state_q == StIdle);
  assign accept        = bus.cmd_valid_i && (state_q == StIdle);
  assign cmd_len_clamp = (bus.cmd_len_i > LW'(MAX_NUM_ELEM)) ? LW'(MAX_NUM_ELEM) : bus.cmd_len_i;

  // In IDLE the next beat is beat 0 of the incoming command; in STREAM it is beat_q.
  assign sel_len   = (state_q == StIdle) ? cmd_len_clamp : len_q;
  assign sel_beat  = (state_q == StIdle) ? '0 : beat_q;
  assign len_round = {1'b0, sel_len} + (LW + 1)'(NUM_LANES - 1);
  assign num_beats = BW'(len_round / (LW + 1)'(NUM_LANES));
  assign is_last   = (sel_beat == num_beats - BW'(1));

  // Lane gather; a write landing in the accept cycle is forwarded so beat 0 sees it.
  always_comb begin
    lane_idx = '0;
    lane_a   = '0;
    lane_b   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_idx[i] = LW'(sel_beat) * LW'(NUM_LANES) + LW'(i);
      if (lane_idx[i] < sel_len) begin
        lane_a[i] = buf_a[lane_idx[i][AW-1:0]];
        lane_b[i] = buf_b[lane_idx[i][AW-1:0]];
        if (wr_ok && (bus.wr_addr_i == lane_idx[i][AW-1:0])) begin
          if (bus.wr_sel_i) lane_b[i] = bus.wr_data_i;
          else              lane_a[i] = bus.wr_data_i;
        end
      end
    end
  end

  // Element buffers are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (bus.wr_sel_i) buf_b[bus.wr_addr_i] <= bus.wr_data_i;
      else              buf_a[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      beat_q      <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      last_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            len_q <= cmd_len_clamp;
            if (cmd_len_clamp == '0) begin
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
              state_q     <= StHoldRes;
            end else begin
              valid_q <= 1'b1;
              start_q <= 1'b1;
              last_q  <= is_last;
              a_q     <= lane_a;
              b_q     <= lane_b;
              beat_q  <= BW'(1);
              state_q <= StStream;
            end
          end
        end
        StStream: begin
          if (beat_q < num_beats) begin
            valid_q <= 1'b1;
            start_q <= 1'b0;
            last_q  <= is_last;
            a_q     <= lane_a;
            b_q     <= lane_b;
            beat_q  <= beat_q + BW'(1);
          end else begin
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            beat_q  <= '0;
            state_q <= StWaitRes;
          end
        end
        StWaitRes: begin
          if (bus.mac_valid_i) begin
            res_data_q  <= bus.mac_data_i;
            res_valid_q <= 1'b1;
            state_q     <= StHoldRes;
          end
        end
        StHoldRes: begin
          if (bus.res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready_o = (state_q == StIdle);
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.valid_o     = valid_q;
  assign bus.start_o     = start_q;
  assign bus.last_o      = last_q;
  assign bus.A_o         = a_q;
  assign bus.B_o         = b_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
endmodule

// File: tb/tb_simd_vector_feeder.sv
// Directed bench for simd_vector_feeder with default parameters (4 lanes x 16 bits, depth 64).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_simd_vector_feeder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  simd_vector_feeder_if bus ();

  simd_vector_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Return the held result to IDLE and confirm the handshake took.
  task automatic finish_result(input string tag);
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    chk1({tag, "_res_valid_drop"}, bus.res_valid_o, 1'b0);
    chk1({tag, "_cmd_ready_back"}, bus.cmd_ready_o, 1'b1);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.wr_en_i     = 1'b0;
    bus.wr_sel_i    = 1'b0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_len_i   = '0;
    bus.mac_valid_i = 1'b0;
    bus.mac_data_i  = '0;
    bus.res_ready_i = 1'b0;

    // Reset state
    #2;
    chk1("rst_valid", bus.valid_o, 1'b0);
    chk1("rst_start", bus.start_o, 1'b0);
    chk1("rst_last", bus.last_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk1("rst_res_valid", bus.res_valid_o, 1'b0);
    chkv("rst_A", bus.A_o, 64'h0);
    chkv("rst_B", bus.B_o, 64'h0);
    chkv("rst_res_data", 64'(bus.res_data_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_cmd_ready", bus.cmd_ready_o, 1'b1);

    // A[0..6]=1..7, B[0..7]=2; A[7]=8 is written in the same cycle as the command.
    for (int i = 0; i < 7; i++) begin
      bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b0; bus.wr_addr_i = 6'(i); bus.wr_data_i = 16'(i + 1);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b1; bus.wr_addr_i = 6'(i); bus.wr_data_i = 16'd2;
      @(negedge clk);
    end
    bus.wr_sel_i = 1'b0; bus.wr_addr_i = 6'd7; bus.wr_data_i = 16'd8;
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = 7'd8;
    @(negedge clk);
    bus.wr_en_i = 1'b0; bus.cmd_valid_i = 1'b0;

    // len=8: two full beats
    chk1("l8_b0_valid", bus.valid_o, 1'b1);
    chk1("l8_b0_start", bus.start_o, 1'b1);
    chk1("l8_b0_last", bus.last_o, 1'b0);
    chkv("l8_b0_A", bus.A_o, 64'h0004_0003_0002_0001);
    chkv("l8_b0_B", bus.B_o, 64'h0002_0002_0002_0002);
    chk1("l8_b0_cmd_ready", bus.cmd_ready_o, 1'b0);
    chk1("l8_b0_busy", bus.busy_o, 1'b1);
    @(negedge clk);
    chk1("l8_b1_valid", bus.valid_o, 1'b1);
    chk1("l8_b1_start", bus.start_o, 1'b0);
    chk1("l8_b1_last", bus.last_o, 1'b1);
    chkv("l8_b1_A", bus.A_o, 64'h0008_0007_0006_0005);
    @(negedge clk);
    chk1("l8_wait_valid", bus.valid_o, 1'b0);
    chk1("l8_wait_last", bus.last_o, 1'b0);
    chkv("l8_wait_A", bus.A_o, 64'h0);
    chk1("l8_wait_busy", bus.busy_o, 1'b1);
    chk1("l8_wait_res_valid", bus.res_valid_o, 1'b0);
    bus.mac_valid_i = 1'b1; bus.mac_data_i = 38'sd72;
    @(negedge clk);
    bus.mac_valid_i = 1'b0; bus.mac_data_i = 38'sd999;
    chk1("l8_res_valid", bus.res_valid_o, 1'b1);
    chkv("l8_res_data", 64'(bus.res_data_o), 64'd72);
    // Result held while the consumer stalls
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("hold_res_valid", bus.res_valid_o, 1'b1);
      chkv("hold_res_data", 64'(bus.res_data_o), 64'd72);
    end
    finish_result("l8");

    // len=5: partial second beat; command and A[0]=99 write attempted mid-stream
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = 7'd5;
    @(negedge clk);
    chk1("l5_b0_cmd_ready", bus.cmd_ready_o, 1'b0);
    chk1("l5_b0_start", bus.start_o, 1'b1);
    chk1("l5_b0_last", bus.last_o, 1'b0);
    chkv("l5_b0_A", bus.A_o, 64'h0004_0003_0002_0001);
    bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b0; bus.wr_addr_i = 6'd0; bus.wr_data_i = 16'd99;
    @(negedge clk);
    bus.wr_en_i = 1'b0; bus.cmd_valid_i = 1'b0;
    chk1("l5_b1_valid", bus.valid_o, 1'b1);
    chk1("l5_b1_start", bus.start_o, 1'b0);
    chk1("l5_b1_last", bus.last_o, 1'b1);
    chkv("l5_b1_A", bus.A_o, 64'h0000_0000_0000_0005);
    chkv("l5_b1_B", bus.B_o, 64'h0000_0000_0000_0002);
    @(negedge clk);
    chk1("l5_end_valid", bus.valid_o, 1'b0);
    bus.mac_valid_i = 1'b1; bus.mac_data_i = 38'sd30;
    @(negedge clk);
    bus.mac_valid_i = 1'b0;
    chkv("l5_res_data", 64'(bus.res_data_o), 64'd30);
    finish_result("l5");

    // len=3: single beat; A[0] must still be 1
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = 7'd3;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk1("l3_valid", bus.valid_o, 1'b1);
    chk1("l3_start", bus.start_o, 1'b1);
    chk1("l3_last", bus.last_o, 1'b1);
    chkv("l3_A", bus.A_o, 64'h0000_0003_0002_0001);
    chkv("l3_B", bus.B_o, 64'h0000_0002_0002_0002);
    @(negedge clk);
    chk1("l3_one_beat", bus.valid_o, 1'b0);
    bus.mac_valid_i = 1'b1; bus.mac_data_i = 38'sd12;
    @(negedge clk);
    bus.mac_valid_i = 1'b0;
    chkv("l3_res_data", 64'(bus.res_data_o), 64'd12);
    finish_result("l3");

    // mac_valid in IDLE is ignored; len=0 goes straight to a zero result
    bus.mac_valid_i = 1'b1; bus.mac_data_i = 38'sd123;
    @(negedge clk);
    bus.mac_valid_i = 1'b0;
    chk1("idle_mac_res_valid", bus.res_valid_o, 1'b0);
    chk1("idle_mac_busy", bus.busy_o, 1'b0);
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = 7'd0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk1("l0_valid", bus.valid_o, 1'b0);
    chk1("l0_res_valid", bus.res_valid_o, 1'b1);
    chkv("l0_res_data", 64'(bus.res_data_o), 64'd0);
    chk1("l0_busy", bus.busy_o, 1'b1);
    finish_result("l0");

    // Reset on beat 1 of a len=8 stream, then a clean len=4 command
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = 7'd8;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk1("rs_b0_valid", bus.valid_o, 1'b1);
    @(negedge clk);
    chkv("rs_b1_A", bus.A_o, 64'h0008_0007_0006_0005);
    rst_n = 1'b0;
    #1;
    chk1("rs_valid", bus.valid_o, 1'b0);
    chk1("rs_busy", bus.busy_o, 1'b0);
    chk1("rs_last", bus.last_o, 1'b0);
    chkv("rs_A", bus.A_o, 64'h0);
    @(negedge clk);
    chk1("rs_held_valid", bus.valid_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rs_cmd_ready", bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = 7'd4;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk1("l4_valid", bus.valid_o, 1'b1);
    chk1("l4_start", bus.start_o, 1'b1);
    chk1("l4_last", bus.last_o, 1'b1);
    chkv("l4_A", bus.A_o, 64'h0004_0003_0002_0001);
    chkv("l4_B", bus.B_o, 64'h0002_0002_0002_0002);
    @(negedge clk);
    chk1("l4_one_beat", bus.valid_o, 1'b0);
    bus.mac_valid_i = 1'b1; bus.mac_data_i = 38'sd20;
    @(negedge clk);
    bus.mac_valid_i = 1'b0;
    chkv("l4_res_data", 64'(bus.res_data_o), 64'd20);
    finish_result("l4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
